// File: rtl/sha_multiround_expand_stage.sv
// sha_multiround_expand_stage: ROUNDS chained SHA-256 compression rounds starting at BASE_ROUND,
// optional on-the-fly schedule expansion, then a PIPELINE_DEPTH register pipeline
// (latency = PIPELINE_DEPTH enabled clocks; en_i=0 freezes every register, so upstream must hold).
// Optional feature macro: SHA_STAGE_BLOCK_COUNT_EN (adds the blocks_o valid-block counter).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en_i              pipeline advance enable
//   state_i / state_o working state, word 0 = a ... word 7 = h
//   W_i / W_o         16-word schedule window, word 0 is the word for the current round
//   valid_i / valid_o qualifier; newblock_i / newblock_o first-chunk marker
//   blocks_o          count of valid newblock outputs (0 when the macro is undefined)
module sha_multiround_expand_stage #(
  parameter int BASE_ROUND     = 0,
  parameter int ROUNDS         = 1,
  parameter int PIPELINE_DEPTH = 1,
  parameter int EXPAND         = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [7:0][31:0]  state_i,
  input  logic [15:0][31:0] W_i,
  input  logic              valid_i,
  input  logic              newblock_i,
  output logic [7:0][31:0]  state_o,
  output logic [15:0][31:0] W_o,
  output logic              valid_o,
  output logic              newblock_o,
  output logic [31:0]       blocks_o
);

  // Elaboration-time range checks on the stage configuration.
  if (ROUNDS < 1 || ROUNDS > 16 || BASE_ROUND < 0 || BASE_ROUND + ROUNDS > 64 ||
      PIPELINE_DEPTH < 0 || PIPELINE_DEPTH > 4) begin : g_bad_params
    $error("sha_multiround_expand_stage: illegal BASE_ROUND/ROUNDS/PIPELINE_DEPTH");
  end

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Combinational round chain: st_d / w_d feed the first pipeline register.
  logic [7:0][31:0]  st_d;
  logic [15:0][31:0] w_d;
  logic [31:0]       t1;
  logic [31:0]       t2;
  logic [31:0]       w15;
  logic [5:0]        kidx;

  always_comb begin
    st_d = state_i;
    w_d  = W_i;
    t1   = '0;
    t2   = '0;
    w15  = '0;
    kidx = '0;
    for (int r = 0; r < ROUNDS; r++) begin
      kidx = 6'(BASE_ROUND + r);
      t1 = st_d[7] + big_sigma1(st_d[4]) + ch(st_d[4], st_d[5], st_d[6]) + K[kidx] + w_d[0];
      t2 = big_sigma0(st_d[0]) + maj(st_d[0], st_d[1], st_d[2]);
      // {h,g,f,e,d,c,b,a} <= {g,f,e,d+T1,c,b,a,T1+T2}
      st_d = {st_d[6:4], st_d[3] + t1, st_d[2:0], t1 + t2};
      // Slot 15 receives W[t+16] when expanding, or the retired word W[t] in legacy mode.
      if (EXPAND != 0) begin
        w15 = small_sigma1(w_d[14]) + w_d[9] + small_sigma0(w_d[1]) + w_d[0];
      end else begin
        w15 = w_d[0];
      end
      w_d = {w15, w_d[15:1]};
    end
  end

  if (PIPELINE_DEPTH == 0) begin : g_comb
    assign state_o    = st_d;
    assign W_o        = w_d;
    assign valid_o    = valid_i;
    assign newblock_o = newblock_i;
  end else begin : g_pipe
    logic [7:0][31:0]  st_q    [PIPELINE_DEPTH];
    logic [15:0][31:0] w_q     [PIPELINE_DEPTH];
    logic              valid_q [PIPELINE_DEPTH];
    logic              nb_q    [PIPELINE_DEPTH];

    // Data registers advance regardless of valid; valid_o alone qualifies them.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PIPELINE_DEPTH; i++) begin
          st_q[i]    <= '0;
          w_q[i]     <= '0;
          valid_q[i] <= 1'b0;
          nb_q[i]    <= 1'b0;
        end
      end else if (en_i) begin
        st_q[0]    <= st_d;
        w_q[0]     <= w_d;
        valid_q[0] <= valid_i;
        nb_q[0]    <= newblock_i;
        for (int i = 1; i < PIPELINE_DEPTH; i++) begin
          st_q[i]    <= st_q[i-1];
          w_q[i]     <= w_q[i-1];
          valid_q[i] <= valid_q[i-1];
          nb_q[i]    <= nb_q[i-1];
        end
      end
    end

    assign state_o    = st_q[PIPELINE_DEPTH-1];
    assign W_o        = w_q[PIPELINE_DEPTH-1];
    assign valid_o    = valid_q[PIPELINE_DEPTH-1];
    assign newblock_o = nb_q[PIPELINE_DEPTH-1];
  end

`ifdef SHA_STAGE_BLOCK_COUNT_EN
  logic [31:0] blocks_q;
  logic [31:0] blocks_d;
  logic        count_en;

  // A held (stalled) output must not be counted again; a combinational stage counts every edge.
  assign count_en = valid_o && newblock_o && (en_i || (PIPELINE_DEPTH == 0));
  assign blocks_d = count_en ? blocks_q + 32'd1 : blocks_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blocks_q <= '0;
    end else begin
      blocks_q <= blocks_d;
    end
  end

  assign blocks_o = blocks_q;
`else
  assign blocks_o = '0;
`endif

endmodule

// File: tb/tb_sha_multiround_expand_stage.sv
module tb_sha_multiround_expand_stage;

  typedef logic [7:0][31:0]  hstate_t;
  typedef logic [15:0][31:0] win_t;
  typedef struct {
    hstate_t st;
    win_t    w;
    logic    nb;
  } exp_t;

  localparam int M_BASE   = 0;
  localparam int M_ROUNDS = 2;

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV_TB [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] DIGEST_ABC [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];
  exp_t last_exp;

  // main DUT: 2 rounds, 2 register stages, expansion on
  logic        en;
  logic        valid_in;
  logic        nb_in;
  hstate_t     st_in;
  win_t        w_in;
  hstate_t     state_o;
  win_t        W_o;
  logic        valid_o;
  logic        newblock_o;
  logic [31:0] blocks_o;

  // single-round legacy-rotation DUT
  logic        r1_v_in;
  hstate_t     r1_st_in;
  win_t        r1_w_in;
  hstate_t     r1_st_o;
  win_t        r1_w_o;
  logic        r1_v_o;
  logic        r1_nb_o;
  logic [31:0] r1_blk_o;

  // four-stage full 64-round chain
  hstate_t     c_st_in;
  win_t        c_w_in;
  logic        c_v_in;
  hstate_t     c_st  [5];
  win_t        c_w   [5];
  logic        c_v   [5];
  logic        c_nb  [5];
  logic [31:0] c_blk [4];

  assign c_st[0] = c_st_in;
  assign c_w[0]  = c_w_in;
  assign c_v[0]  = c_v_in;
  assign c_nb[0] = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  sha_multiround_expand_stage #(
    .BASE_ROUND(M_BASE), .ROUNDS(M_ROUNDS), .PIPELINE_DEPTH(2), .EXPAND(1)
  ) u_dut (
    .clk(clk), .rst(rst), .en_i(en), .state_i(st_in), .W_i(w_in),
    .valid_i(valid_in), .newblock_i(nb_in), .state_o(state_o), .W_o(W_o),
    .valid_o(valid_o), .newblock_o(newblock_o), .blocks_o(blocks_o)
  );

  sha_multiround_expand_stage #(
    .BASE_ROUND(0), .ROUNDS(1), .PIPELINE_DEPTH(1), .EXPAND(0)
  ) u_r1 (
    .clk(clk), .rst(rst), .en_i(1'b1), .state_i(r1_st_in), .W_i(r1_w_in),
    .valid_i(r1_v_in), .newblock_i(1'b0), .state_o(r1_st_o), .W_o(r1_w_o),
    .valid_o(r1_v_o), .newblock_o(r1_nb_o), .blocks_o(r1_blk_o)
  );

  for (genvar g = 0; g < 4; g++) begin : g_chain
    sha_multiround_expand_stage #(
      .BASE_ROUND(16 * g), .ROUNDS(16), .PIPELINE_DEPTH(1), .EXPAND(1)
    ) u_stage (
      .clk(clk), .rst(rst), .en_i(1'b1), .state_i(c_st[g]), .W_i(c_w[g]),
      .valid_i(c_v[g]), .newblock_i(c_nb[g]), .state_o(c_st[g+1]), .W_o(c_w[g+1]),
      .valid_o(c_v[g+1]), .newblock_o(c_nb[g+1]), .blocks_o(c_blk[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  // Reference: expand the full schedule array, then run the rounds on named registers.
  task automatic ref_stage(input hstate_t si, input win_t wi, output hstate_t so, output win_t wo);
    logic [31:0] sch [32];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) sch[i] = wi[i];
    for (int t = 16; t < 32; t++) sch[t] = ss1(sch[t-2]) + sch[t-7] + ss0(sch[t-15]) + sch[t-16];
    a = si[0]; b = si[1]; c = si[2]; d = si[3];
    e = si[4]; f = si[5]; g = si[6]; h = si[7];
    for (int r = 0; r < M_ROUNDS; r++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K_TB[M_BASE + r] + sch[r];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    so = {h, g, f, e, d, c, b, a};
    for (int i = 0; i < 16; i++) wo[i] = sch[M_ROUNDS + i];
  endtask

  function automatic hstate_t rand_state();
    hstate_t s;
    for (int i = 0; i < 8; i++) s[i] = $urandom();
    return s;
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int i = 0; i < 16; i++) w[i] = $urandom();
    return w;
  endfunction

  task automatic drive_main(input logic v, input logic nb, input logic e, input hstate_t s, input win_t w);
    exp_t    x;
    hstate_t so;
    win_t    wo;
    en = e; valid_in = v; nb_in = nb; st_in = s; w_in = w;
    if (e && v) begin
      ref_stage(s, w, so, wo);
      x.st = so; x.w = wo; x.nb = nb;
      sb.push_back(x);
    end
  endtask

  task automatic drive_idle();
    drive_main(1'b0, 1'b0, 1'b1, rand_state(), rand_win());
  endtask

  // Scoreboard monitor: an output is new only after an enabled edge.
  initial begin
    exp_t x;
    logic en_s;
    forever begin
      @(posedge clk);
      en_s = en;
      #2;
      if (en_s && !rst && valid_o) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          x = sb.pop_front();
          last_exp = x;
          for (int i = 0; i < 8; i++) check("sb_state", state_o[i], x.st[i]);
          for (int i = 0; i < 16; i++) check("sb_window", W_o[i], x.w[i]);
          check("sb_newblock", 32'(newblock_o), 32'(x.nb));
        end
      end
    end
  end

  initial begin
    hstate_t abc_st;
    win_t    abc_w;
    logic    cv [8];
    logic    cn [8];
    logic [31:0] exp_blocks;

    cv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    cn = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 8; i++) abc_st[i] = IV_TB[i];
    abc_w     = '0;
    abc_w[0]  = 32'h61626380;
    abc_w[15] = 32'h00000018;

    rst = 1'b1;
    en = 1'b0; valid_in = 1'b0; nb_in = 1'b0; st_in = '0; w_in = '0;
    r1_v_in = 1'b0; r1_st_in = '0; r1_w_in = '0;
    c_v_in = 1'b0; c_st_in = '0; c_w_in = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_newblock", 32'(newblock_o), 32'd0);
    check("rst_state_a", state_o[0], 32'd0);
    check("rst_state_h", state_o[7], 32'd0);
    check("rst_window15", W_o[15], 32'd0);
    check("rst_blocks", blocks_o, 32'd0);

    // "abc" through all three configurations at once
    @(negedge clk);
    rst = 1'b0;
    drive_main(1'b1, 1'b1, 1'b1, abc_st, abc_w);
    r1_v_in = 1'b1; r1_st_in = abc_st; r1_w_in = abc_w;
    c_v_in  = 1'b1; c_st_in  = abc_st; c_w_in  = abc_w;
    @(posedge clk); #2;
    check("r1_valid", 32'(r1_v_o), 32'd1);
    check("r1_a", r1_st_o[0], 32'h5d6aebcd);
    check("r1_e", r1_st_o[4], 32'hfa2a4622);
    check("r1_rot_w15", r1_w_o[15], 32'h61626380);
    check("r1_rot_w14", r1_w_o[14], 32'h00000018);
    check("main_lat_edge1", 32'(valid_o), 32'd0);

    @(negedge clk);
    drive_idle();
    r1_v_in = 1'b0; c_v_in = 1'b0;
    @(posedge clk); #2;
    check("main_lat_edge2", 32'(valid_o), 32'd1);
    check("abc2_a", state_o[0], 32'h5a6ad9ad);
    check("abc2_e", state_o[4], 32'h78ce7989);
    check("abc2_w14", W_o[14], 32'h61626380);
    check("abc2_w15", W_o[15], 32'h000f0000);

    @(negedge clk);
    drive_idle();
    @(posedge clk); #2;
    check("chain_lat_edge3", 32'(c_v[4]), 32'd0);
    @(negedge clk);
    drive_idle();
    @(posedge clk); #2;
    check("chain_valid_edge4", 32'(c_v[4]), 32'd1);
    for (int i = 0; i < 8; i++) check("chain_digest", c_st[4][i] + IV_TB[i], DIGEST_ABC[i]);

    // random traffic with random enable gaps
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive_main($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, rand_state(), rand_win());
    end
    repeat (3) begin
      @(negedge clk);
      drive_idle();
    end

    // reset with two valid blocks in flight
    @(negedge clk);
    drive_main(1'b1, 1'b1, 1'b1, rand_state(), rand_win());
    @(negedge clk);
    drive_main(1'b1, 1'b1, 1'b1, rand_state(), rand_win());
    @(negedge clk);
    #1;
    rst = 1'b1;
    en = 1'b1; valid_in = 1'b0; nb_in = 1'b0;
    sb.delete();
    #1;
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_newblock", 32'(newblock_o), 32'd0);
    check("arst_blocks", blocks_o, 32'd0);
    check("arst_state_a", state_o[0], 32'd0);
    check("arst_window0", W_o[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      check("no_stale_block", 32'(valid_o), 32'd0);
      @(negedge clk);
      drive_idle();
    end

    // counter run with a 3-cycle stall while a valid newblock sits at the output
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          drive_main(1'b1, 1'b1, 1'b0, rand_state(), rand_win());
          @(posedge clk); #2;
          check("stall_valid", 32'(valid_o), 32'd1);
          check("stall_newblock", 32'(newblock_o), 32'd1);
          check("stall_a", state_o[0], last_exp.st[0]);
          check("stall_e", state_o[4], last_exp.st[4]);
          check("stall_w15", W_o[15], last_exp.w[15]);
        end
      end
      @(negedge clk);
      drive_main(cv[i], cn[i], 1'b1, rand_state(), rand_win());
    end
    repeat (3) begin
      @(negedge clk);
      drive_idle();
    end
    @(posedge clk); #2;
`ifdef SHA_STAGE_BLOCK_COUNT_EN
    exp_blocks = 32'd3;
`else
    exp_blocks = 32'd0;
`endif
    check("block_count", blocks_o, exp_blocks);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
